// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
package alu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_NOT  = 4'd7,
    OP_SHL1 = 4'd8,
    OP_ADC  = 4'd9,
    OP_SBC  = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_RSVD = 4'd13
  } alu_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_var_shift(input logic [OPC_W-1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational evaluation of the single-cycle opcodes; returns {carry, result}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OPC_W-1:0] i_sel,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_cr
);

  logic [WIDTH:0] w_a;
  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_nb;
  logic [WIDTH:0] w_cin;

  assign w_a   = {1'b0, i_a};
  assign w_b   = {1'b0, i_b};
  assign w_nb  = {1'b0, ~i_b};
  assign w_cin = {{WIDTH{1'b0}}, i_cin};

  // Sums are WIDTH+1 wide so the top bit is the carry (no-borrow for subtracts).
  always_comb begin
    o_cr = '0;
    case (i_sel)
      OP_ADD:  o_cr = w_a + w_b;
      OP_SUB:  o_cr = w_a + w_nb + (WIDTH+1)'(1);
      OP_INC:  o_cr = w_a + (WIDTH+1)'(1);
      OP_DEC:  o_cr = w_a + {1'b0, {WIDTH{1'b1}}};
      OP_AND:  o_cr = {1'b0, i_a & i_b};
      OP_OR:   o_cr = {1'b0, i_a | i_b};
      OP_XOR:  o_cr = {1'b0, i_a ^ i_b};
      OP_NOT:  o_cr = {1'b0, ~i_a};
      OP_SHL1: o_cr = {i_a, 1'b0};
      OP_ADC:  o_cr = w_a + w_b + w_cin;
      OP_SBC:  o_cr = w_a + w_nb + w_cin;
      default: o_cr = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops load the output register on accept; variable
// shifts iterate one bit per cycle in a working register before loading.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPC_W-1:0] sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_flag,
  output logic             z_flag,
  output alu_state_t       o_dbg_state
);

  // Handshake: a request transfers on any edge where in_valid && in_ready; a
  // result transfers on any edge where out_valid && out_ready. Neither side may
  // retract nor alter a presented item until it transfers.

  alu_state_t         r_state;
  alu_state_t         w_state_nxt;
  logic [WIDTH-1:0]   r_work;
  logic               r_dir;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_c;
  logic               r_z;

  logic               w_accept;
  logic               w_var_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH:0]     w_core_cr;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic               w_shift_out;
  logic               w_load;
  logic               w_start;
  logic [WIDTH:0]     w_load_cr;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .i_a   (a),
    .i_b   (b),
    .i_sel (sel),
    .i_cin (r_c),
    .o_cr  (w_core_cr)
  );

  assign in_ready    = (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign w_var_shift = is_var_shift(sel);
  assign w_shamt     = b[SHAMT_W-1:0];
  assign w_shift_nxt = r_dir ? (r_work >> 1) : (r_work << 1);
  assign w_shift_out = r_dir ? r_work[0] : r_work[WIDTH-1];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_load_cr   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_var_shift && (w_shamt != '0)) begin
            w_start     = 1'b1;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_load    = 1'b1;
            w_load_cr = w_var_shift ? {1'b0, a} : w_core_cr;
          end
        end
      end
      ST_SHIFT: begin
        // The final shift step produces the result and its carry directly.
        if (r_cnt == SHAMT_W'(1)) begin
          w_load      = 1'b1;
          w_load_cr   = {w_shift_out, w_shift_nxt};
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_dir  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_start) begin
      r_work <= a;
      r_dir  <= (sel == OP_SHR);
      r_cnt  <= w_shamt;
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_shift_nxt;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

  // A load wins over a consume, so simultaneous consume+load keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_load_cr[WIDTH-1:0];
      r_c         <= w_load_cr[WIDTH];
      r_z         <= (w_load_cr[WIDTH-1:0] == '0);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign c_flag      = r_c;
  assign z_flag      = r_z;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed scenarios, then random ops against an arithmetic model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    sel = '0;
  logic          out_valid;
  wire           out_ready;
  logic [W-1:0]  result;
  logic          c_flag;
  logic          z_flag;
  alu_state_t    dbg_state;

  logic          rand_ready = 1'b0;
  logic          rand_rdy_bit = 1'b1;
  logic          ready_force = 1'b1;
  assign out_ready = rand_ready ? rand_rdy_bit : ready_force;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  bit            c_model = 1'b0;
  logic [W+1:0]  exp_q[$];
  logic          stall_prev = 1'b0;
  logic [W+1:0]  held = '0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sel         (sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .c_flag      (c_flag),
    .z_flag      (z_flag),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    #1;
    rand_rdy_bit = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, cycles=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {c, z, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input int op, input logic [W-1:0] av,
                                         input logic [W-1:0] bv, input bit cin);
    longint x = longint'(av);
    longint y = longint'(bv);
    longint m = longint'(1) << W;
    longint full;
    int n = int'(bv[SW-1:0]);
    logic [W-1:0] r;
    case (op)
      0:  full = x + y;
      1:  full = x - y + m;
      2:  full = x + 1;
      3:  full = x - 1 + m;
      4:  full = x & y;
      5:  full = x | y;
      6:  full = x ^ y;
      7:  full = m - 1 - x;
      8:  full = x * 2;
      9:  full = x + y + longint'(cin);
      10: full = x - y - 1 + longint'(cin) + m;
      11: full = (n == 0) ? x : (x << n);
      12: full = (n == 0) ? x : ((x >> n) | (((x >> (n - 1)) & 1) << W));
      default: full = 0;
    endcase
    r = full[W-1:0];
    return {full[W], (r == '0), r};
  endfunction

  // Scoreboard: every consumed result must match the oldest expected one.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("hold", {c_flag, z_flag, result}, held);
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("result", {c_flag, z_flag, result}, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held = {c_flag, z_flag, result};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    int waited = 0;
    logic [W+1:0] e;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    sel = op;
    a = av;
    b = bv;
    #1;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      #2;
      waited++;
    end
    check("accept_timeout", waited < 64, 1);
    if (in_ready) begin
      e = model(int'(op), av, bv, c_model);
      c_model = e[W+1];
      exp_q.push_back(e);
      acc_cyc = cyc;
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] r, input logic c, input logic z);
    check(tag, {out_valid, c_flag, z_flag, result}, {1'b1, c, z, r});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int prev;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_outs", {out_valid, c_flag, z_flag, result}, '0);
    #1 rst_n = 1'b1;
    #1 check("rst_in_ready", in_ready, 1);

    send(OP_ADD, 16'd1, 16'd2);  sample(); expect_out("add", 16'd3, 1'b0, 1'b0);
    send(OP_SUB, 16'd1, 16'd2);  sample(); expect_out("sub", 16'hFFFF, 1'b0, 1'b0);
    send(OP_INC, 16'hFFFF, 16'd0); sample(); expect_out("inc", 16'd0, 1'b1, 1'b1);
    send(OP_ADC, 16'd0, 16'd0);  sample(); expect_out("adc", 16'd1, 1'b0, 1'b0);
    send(OP_SBC, 16'd5, 16'd5);  sample(); expect_out("sbc", 16'hFFFF, 1'b0, 1'b0);

    send(OP_SHL, 16'h8001, 16'd4);
    repeat (4) begin
      sample();
      check("shl_busy", {in_ready, out_valid}, 2'b00);
      check("shl_state", dbg_state, ST_SHIFT);
    end
    sample(); expect_out("shl4", 16'h0010, 1'b0, 1'b0);
    send(OP_SHL, 16'h8001, 16'd1);
    sample(); check("shl1_busy", {in_ready, out_valid}, 2'b00);
    sample(); expect_out("shl_by1", 16'h0002, 1'b1, 1'b0);
    send(OP_SHR, 16'h1234, 16'd0); sample(); expect_out("shr0", 16'h1234, 1'b0, 1'b0);

    // Backpressure with a pending XOR that must not be taken.
    @(posedge clk); #1 ready_force = 1'b0;
    send(OP_ADD, 16'd1, 16'd2); sample(); expect_out("bp_add", 16'd3, 1'b0, 1'b0);
    in_valid = 1'b1; sel = OP_XOR; a = 16'd1; b = 16'd2;
    repeat (3) begin
      sample();
      expect_out("bp_hold", 16'd3, 1'b0, 1'b0);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ready_force = 1'b1;
    send(OP_XOR, 16'd1, 16'd2); sample(); expect_out("bp_xor", 16'd3, 1'b0, 1'b0);

    // Back-to-back accepts on consecutive edges.
    send(OP_ADD, 16'd10, 16'd20); prev = acc_cyc;
    #1 expect_out("b2b_0", 16'd30, 1'b0, 1'b0);
    send(OP_ADD, 16'd100, 16'd200);
    check("b2b_gap1", acc_cyc - prev, 1); prev = acc_cyc;
    #1 expect_out("b2b_1", 16'd300, 1'b0, 1'b0);
    send(OP_ADD, 16'hFFFF, 16'd1);
    check("b2b_gap2", acc_cyc - prev, 1);
    #1 expect_out("b2b_2", 16'd0, 1'b1, 1'b1);

    // Reset in the middle of the longest shift.
    send(OP_SHR, 16'hFFFF, 16'd15);
    repeat (3) sample();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outs", {out_valid, c_flag, z_flag, result}, '0);
    check("midrst_state", dbg_state, ST_IDLE);
    exp_q.delete();
    c_model = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 check("midrst_in_ready", in_ready, 1);
    send(4'd13, W'($urandom), W'($urandom)); sample(); expect_out("rsvd", 16'd0, 1'b0, 1'b1);

    // Random traffic with random output backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
      logic [W-1:0] av, bv;
      op = 4'($urandom_range(0, 15));
      av = W'($urandom);
      bv = W'($urandom);
      case ($urandom_range(0, 7))
        0: av = '0;
        1: av = '1;
        2: bv = '0;
        3: bv = '1;
        default: ;
      endcase
      send(op, av, bv);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    rand_ready = 1'b0;
    for (int k = 0; k < 100 && exp_q.size() > 0; k++) sample();
    check("drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
